// File: rtl/ex_muldiv_pkg.sv
// Decode constants, FSM states and the result-select helper shared
// by the ex_muldiv EX-stage multiply/divide unit.
package ex_muldiv_pkg;

    localparam int MD_XLEN = 32;

    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] FUNCT7_M      = 7'b0000001;

    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;
    localparam logic [2:0] INST_DIV    = 3'b100;
    localparam logic [2:0] INST_DIVU   = 3'b101;
    localparam logic [2:0] INST_REM    = 3'b110;
    localparam logic [2:0] INST_REMU   = 3'b111;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

    // acc holds the magnitude result: product, or {remainder, quotient}
    function automatic logic [31:0] md_result(
        input logic [2:0]  f3,
        input logic [63:0] acc,
        input logic        q_neg,
        input logic        r_neg
    );
        logic [63:0] prod;
        logic [31:0] quo;
        logic [31:0] rem;
        logic [31:0] res;
        prod = q_neg ? -acc : acc;
        quo  = q_neg ? -acc[31:0] : acc[31:0];
        rem  = r_neg ? -acc[63:32] : acc[63:32];
        res  = '0;
        unique case (1'b1)
            (f3 == INST_MUL):            res = prod[31:0];
            (!f3[2] && f3 != INST_MUL):  res = prod[63:32];
            (f3[2] && !f3[1]):           res = quo;
            default:                     res = rem;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
import ex_muldiv_pkg::*;

module muldiv_step (
    input  step_mode_e  mode_i,
    input  logic [63:0] acc_i,
    input  logic [31:0] opnd_i,
    input  logic [4:0]  idx_i,
    output logic [63:0] acc_o
);

    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic [4:0]  bit_pos;

    always_comb begin
        acc_o   = acc_i;
        sum     = '0;
        rem_sh  = '0;
        diff    = '0;
        bit_pos = 5'd31 - idx_i;
        if (mode_i == STEP_MUL) begin
            sum   = {1'b0, acc_i[63:32]}
                  + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
            acc_o = {sum, acc_i[31:1]};
        end else begin
            // dividend bit is consumed in place and replaced by the quotient bit
            rem_sh = {acc_i[63:32], acc_i[bit_pos]};
            diff   = rem_sh - {1'b0, opnd_i};
            if (!diff[32]) begin
                acc_o[63:32]   = diff[31:0];
                acc_o[bit_pos] = 1'b1;
            end else begin
                acc_o[63:32]   = rem_sh[31:0];
                acc_o[bit_pos] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M multiply/divide for the EX stage.
// MULDIV_FAST_MUL_EN: single-cycle 33x33 multiply, CALC used by divides only.
import ex_muldiv_pkg::*;

module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [31:0]     inst_i,
    input  logic [4:0]      reg_waddr_i,
    input  logic            flush_i,
    output logic            hold_o,
    output logic            busy_o,
    output logic            reg_we_o,
    output logic [4:0]      reg_waddr_o,
    output logic [XLEN-1:0] reg_wdata_o
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       is_mop;
    logic       start;
    logic       a_signed;
    logic       b_signed;
    logic       a_neg;
    logic       b_neg;
    logic       unused_inst;

    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;

    md_state_e  state_q, state_d;
    step_mode_e step_mode;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] step_acc;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        waddr_q, waddr_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              busy_q, busy_d;

    assign opcode      = inst_i[6:0];
    assign funct7      = inst_i[31:25];
    assign funct3      = inst_i[14:12];
    assign unused_inst = ^{inst_i[24:15], inst_i[11:7]};

    assign is_mop = (opcode == INST_TYPE_R_M) && (funct7 == FUNCT7_M);
    assign start  = (state_q == MD_IDLE) && is_mop && !flush_i;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        unique case (1'b1)
            (funct3 == INST_MULH),
            (funct3 == INST_DIV),
            (funct3 == INST_REM): begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            (funct3 == INST_MULHSU): a_signed = 1'b1;
            default: ;
        endcase
    end

    assign a_neg = a_signed && op1_i[XLEN-1];
    assign b_neg = b_signed && op2_i[XLEN-1];
    assign a_abs = a_neg ? -op1_i : op1_i;
    assign b_abs = b_neg ? -op2_i : op2_i;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN+1:0] fast_p;
    logic [XLEN-1:0]          fast_res;

    always_comb begin
        fast_p   = $signed({a_signed & op1_i[XLEN-1], op1_i})
                 * $signed({b_signed & op2_i[XLEN-1], op2_i});
        fast_res = (funct3 == INST_MUL) ? fast_p[XLEN-1:0]
                                        : fast_p[2*XLEN-1:XLEN];
    end
`endif

    assign step_mode = f3_q[2] ? STEP_DIV : STEP_MUL;

    muldiv_step u_step (
        .mode_i (step_mode),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .idx_i  (cnt_q),
        .acc_o  (step_acc)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        f3_d     = f3_q;
        waddr_d  = waddr_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        unique case (state_q)
            MD_IDLE: begin
                if (start) begin
                    f3_d    = funct3;
                    waddr_d = reg_waddr_i;
                    opnd_d  = b_abs;
                    acc_d   = {{XLEN{1'b0}}, a_abs};
                    cnt_d   = '0;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    state_d = MD_CALC;
                    if (funct3[2] && op2_i == '0) begin
                        result_d = funct3[1] ? op1_i : '1;
                        state_d  = MD_DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!funct3[2]) begin
                        result_d = fast_res;
                        state_d  = MD_DONE;
                    end
`endif
                end
            end
            MD_CALC: begin
                if (flush_i) begin
                    state_d = MD_IDLE;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == {CNT_W{1'b1}}) begin
                        result_d = md_result(f3_q, step_acc,
                                             qneg_q, rneg_q);
                        state_d  = MD_DONE;
                    end
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
        busy_d = (state_d != MD_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            f3_q     <= '0;
            waddr_q  <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            f3_q     <= f3_d;
            waddr_q  <= waddr_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            busy_q   <= busy_d;
        end
    end

    // DONE drops hold so the pipeline advances on the write-back cycle
    assign hold_o      = start || (state_q == MD_CALC && !flush_i);
    assign busy_o      = busy_q;
    assign reg_we_o    = (state_q == MD_DONE) && (waddr_q != '0)
                      && !flush_i;
    assign reg_waddr_o = waddr_q;
    assign reg_wdata_o = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M corners plus
// randomized ops against an arithmetic reference model.
module tb_ex_muldiv;

    logic        clk;
    logic        rst_n;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] inst;
    logic [4:0]  waddr_i;
    logic        flush;
    logic        hold;
    logic        busy;
    logic        we;
    logic [4:0]  waddr_o;
    logic [31:0] wdata;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    ex_muldiv dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op1_i       (op1),
        .op2_i       (op2),
        .inst_i      (inst),
        .reg_waddr_i (waddr_i),
        .flush_i     (flush),
        .hold_o      (hold),
        .busy_o      (busy),
        .reg_we_o    (we),
        .reg_waddr_o (waddr_o),
        .reg_wdata_o (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_inst(input logic [2:0] f3,
                                            input logic [4:0] rd);
        return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          p;
        longint unsigned up;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (f3)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
            3'd3: begin up = ua * ub; r = up[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else begin up = ua / ub; r = up[31:0]; end
            end
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: begin
                if (b == 0) r = a;
                else begin up = ua % ub; r = up[31:0]; end
            end
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] f3,
                                       input logic [31:0] b);
        if (f3[2] && b == 0) return 2;
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2]) return 2;
`endif
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'h7FFF_FFFF;
            5: v = $urandom_range(0, 15);
            default: v = $urandom();
        endcase
        return v;
    endfunction

    // Issues one op and observes it until the first cycle hold_o is low.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          output int lat, output int hcnt,
                          output bit we_seen, output logic [31:0] wd,
                          output logic [4:0] wa);
        @(negedge clk);
        inst    = mk_inst(f3, rd);
        op1     = a;
        op2     = b;
        waddr_i = rd;
        lat     = 0;
        hcnt    = 0;
        we_seen = 0;
        wd      = '0;
        wa      = '0;
        for (int c = 1; c <= 60; c++) begin
            #1;
            if (hold) hcnt++;
            if (we) begin
                we_seen = 1;
                wd      = wdata;
                wa      = waddr_o;
            end
            if (!hold) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (we !== 1'b0)
            begin errors++; $display("FAIL reset_we got=%b exp=0", we); end
        checks++; if (waddr_o !== 5'd0)
            begin errors++; $display("FAIL reset_waddr got=%0d exp=0", waddr_o); end
        checks++; if (wdata !== 32'd0)
            begin errors++; $display("FAIL reset_wdata got=%h exp=0", wdata); end
        checks++; if (busy !== 1'b0)
            begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (hold !== 1'b0)
            begin errors++; $display("FAIL reset_hold got=%b exp=0", hold); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic test_directed();
        vec_t        v[10];
        int          lat;
        int          hcnt;
        int          elat;
        bit          ws;
        logic [31:0] wd;
        logic [4:0]  wa;
        logic [4:0]  rd;
        v = '{
            '{3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD},
            '{3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF},
            '{3'd5, 32'd100,       32'd0,        32'hFFFF_FFFF},
            '{3'd7, 32'd100,       32'd0,        32'd100},
            '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
            '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0},
            '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
            '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{3'd0, 32'd12345,     32'hFFFF_FFFD, 32'hFFFF_6F55}
        };
        foreach (v[i]) begin
            rd   = 5'($urandom_range(1, 31));
            elat = ref_latency(v[i].f3, v[i].b);
            run_op(v[i].f3, v[i].a, v[i].b, rd, lat, hcnt, ws, wd, wa);
            checks++; if (lat !== elat) begin errors++;
                $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, elat); end
            checks++; if (hcnt !== elat - 1) begin errors++;
                $display("FAIL dir%0d_hold got=%0d exp=%0d", i, hcnt, elat - 1); end
            checks++; if (!ws || wd !== v[i].exp) begin errors++;
                $display("FAIL dir%0d_wdata we=%b got=%h exp=%h", i, ws, wd, v[i].exp); end
            checks++; if (wa !== rd) begin errors++;
                $display("FAIL dir%0d_waddr got=%0d exp=%0d", i, wa, rd); end
        end
        @(negedge clk);
        inst = NOP;
    endtask

    task automatic test_random();
        int          lat;
        int          hcnt;
        bit          ws;
        logic [31:0] wd;
        logic [4:0]  wa;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [4:0]  rd;
        for (int i = 0; i < 48; i++) begin
            f3  = 3'($urandom_range(0, 7));
            a   = pick();
            b   = pick();
            rd  = 5'($urandom_range(1, 31));
            exp = ref_result(f3, a, b);
            run_op(f3, a, b, rd, lat, hcnt, ws, wd, wa);
            checks++; if (!ws || wd !== exp || wa !== rd) begin errors++;
                $display("FAIL rnd%0d_f3=%0d a=%h b=%h we=%b got=%h exp=%h rd=%0d/%0d",
                         i, f3, a, b, ws, wd, exp, wa, rd); end
            checks++; if (lat !== ref_latency(f3, b)) begin errors++;
                $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat,
                         ref_latency(f3, b)); end
        end
        @(negedge clk);
        inst = NOP;
    endtask

    task automatic test_flush();
        int          lat;
        int          hcnt;
        bit          ws;
        logic [31:0] wd;
        logic [4:0]  wa;
        logic [31:0] a;
        logic [31:0] b;
        @(negedge clk);
        inst    = mk_inst(3'd5, 5'd5);
        op1     = 32'd1000;
        op2     = 32'd7;
        waddr_i = 5'd5;
        repeat (10) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b1 || hold !== 1'b1) begin errors++;
            $display("FAIL flush_pre busy=%b hold=%b exp=1/1", busy, hold); end
        flush = 1'b1;
        #1;
        checks++; if (hold !== 1'b0 || we !== 1'b0) begin errors++;
            $display("FAIL flush_hold hold=%b we=%b exp=0/0", hold, we); end
        @(negedge clk);
        flush = 1'b0;
        inst  = NOP;
        #1;
        checks++; if (busy !== 1'b0 || we !== 1'b0 || hold !== 1'b0) begin errors++;
            $display("FAIL flush_after busy=%b we=%b hold=%b exp=0/0/0", busy, we, hold); end
        a = pick();
        b = pick();
        run_op(3'd0, a, b, 5'd9, lat, hcnt, ws, wd, wa);
        checks++; if (!ws || wd !== ref_result(3'd0, a, b)) begin errors++;
            $display("FAIL flush_mul we=%b got=%h exp=%h", ws, wd, ref_result(3'd0, a, b)); end
        checks++; if (lat !== ref_latency(3'd0, b)) begin errors++;
            $display("FAIL flush_mul_latency got=%0d exp=%0d", lat, ref_latency(3'd0, b)); end
        @(negedge clk);
        inst = NOP;
    endtask

    task automatic test_reset_mid();
        int          lat;
        int          hcnt;
        bit          ws;
        logic [31:0] wd;
        logic [4:0]  wa;
        @(negedge clk);
        inst    = mk_inst(3'd4, 5'd12);
        op1     = 32'h1234_5678;
        op2     = 32'd3;
        waddr_i = 5'd12;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        inst  = NOP;
        #1;
        checks++; if ({we, waddr_o, wdata, busy, hold} !== '0) begin errors++;
            $display("FAIL rstmid we=%b waddr=%0d wdata=%h busy=%b hold=%b exp=all0",
                     we, waddr_o, wdata, busy, hold); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd6, 32'hFFFF_FF00, 32'd7, 5'd3, lat, hcnt, ws, wd, wa);
        checks++; if (!ws || wd !== ref_result(3'd6, 32'hFFFF_FF00, 32'd7)) begin errors++;
            $display("FAIL rstmid_rem we=%b got=%h exp=%h", ws, wd,
                     ref_result(3'd6, 32'hFFFF_FF00, 32'd7)); end
        @(negedge clk);
        inst = NOP;
    endtask

    task automatic test_rd_zero();
        int          lat;
        int          hcnt;
        bit          ws;
        logic [31:0] wd;
        logic [4:0]  wa;
        logic [2:0]  f3;
        logic [31:0] b;
        for (int i = 0; i < 2; i++) begin
            f3 = (i == 0) ? 3'd0 : 3'd4;
            b  = 32'd5;
            run_op(f3, 32'h0000_0123, b, 5'd0, lat, hcnt, ws, wd, wa);
            checks++; if (ws !== 1'b0) begin errors++;
                $display("FAIL rd0_%0d_we got=%b exp=0", i, ws); end
            checks++; if (lat !== ref_latency(f3, b) || hcnt !== lat - 1) begin errors++;
                $display("FAIL rd0_%0d_latency got=%0d hold=%0d exp=%0d", i, lat, hcnt,
                         ref_latency(f3, b)); end
        end
        @(negedge clk);
        inst = NOP;
    endtask

    initial begin
        rst_n   = 1'b0;
        op1     = '0;
        op2     = '0;
        inst    = NOP;
        waddr_i = '0;
        flush   = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid();
        test_rd_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
